// File: rtl/uart_transmitter.sv
// Framed serial transmitter: a small message FIFO feeds a START/DATA/STOP/GAP
// sequencer that drives a registered, idle-low serial line.
module uart_transmitter #(
    parameter int unsigned MSG_W      = 20,
    parameter int unsigned BIT_CLKS   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_BITS   = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [MSG_W-1:0] msgIn,
    input  logic             msgValid,
    output logic             msgReady,
    output logic             serialOut,
    output logic             busy,
    output logic             frameDone,
    output logic [2:0]       dbg_state
);

    localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int unsigned BMAX = (MSG_W > GAP_BITS) ? MSG_W : GAP_BITS;
    localparam int unsigned BW   = $clog2(BMAX + 1);

    localparam logic [CNTW-1:0] FULL      = CNTW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   CLK_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [BW-1:0]   DATA_LAST = BW'(MSG_W - 1);
    localparam logic [BW-1:0]   GAP_LAST  = BW'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // Handshake: a message transfers on any rising edge where msgValid and
    // msgReady are both high; msgReady does not depend on msgValid.
    state_t            state, state_nxt;
    logic [MSG_W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CNTW-1:0]   count, count_nxt;
    logic [CW-1:0]     clk_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [MSG_W+1:0]  shift;
    logic              push, pop, bit_wrap;
    logic              line_nxt, done_nxt;

    assign push      = msgValid && msgReady;
    assign pop       = (state == S_IDLE) && (count != '0);
    assign bit_wrap  = (clk_cnt == CLK_LAST);
    assign dbg_state = state;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= msgIn;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The shift register MSB is the line level for START, DATA and STOP.
    always_comb begin
        state_nxt = state;
        line_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) state_nxt = S_START;
            end
            S_START: begin
                line_nxt = shift[MSG_W+1];
                if (bit_wrap) state_nxt = S_DATA;
            end
            S_DATA: begin
                line_nxt = shift[MSG_W+1];
                if (bit_wrap && (bit_cnt == DATA_LAST)) state_nxt = S_STOP;
            end
            S_STOP: begin
                line_nxt = shift[MSG_W+1];
                if (bit_wrap) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (bit_wrap && (bit_cnt == GAP_LAST)) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // bit_cnt restarts at every phase change so it indexes data bits or gap bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else if (state == S_IDLE) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            if (pop) shift <= {1'b1, mem[rd_ptr], 1'b0};
        end else begin
            clk_cnt <= bit_wrap ? '0 : clk_cnt + 1'b1;
            if (bit_wrap) begin
                shift   <= {shift[MSG_W:0], 1'b0};
                bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            serialOut <= 1'b0;
            frameDone <= 1'b0;
            busy      <= 1'b0;
            msgReady  <= 1'b0;
        end else begin
            serialOut <= line_nxt;
            frameDone <= done_nxt;
            busy      <= (state_nxt != S_IDLE) || (count_nxt != '0);
            msgReady  <= (count_nxt != FULL);
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: cycle-level frame model, line decoder with an
// expected-message queue, directed scenarios and a random phase.
module tb_uart_transmitter;

    localparam int MSG_W = 20;
    localparam int DEPTH = 4;
    localparam int FRAME = (MSG_W + 3) * 8;

    logic              clock;
    logic              reset_n;
    logic [MSG_W-1:0]  msgIn;
    logic              msgValid;
    logic              msgReady;
    logic              serialOut;
    logic              busy;
    logic              frameDone;
    logic [2:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    uart_transmitter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .msgIn     (msgIn),
        .msgValid  (msgValid),
        .msgReady  (msgReady),
        .serialOut (serialOut),
        .busy      (busy),
        .frameDone (frameDone),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: message queue plus "frame started at edge s" timeline
    logic [MSG_W-1:0] mq[$];
    logic [MSG_W-1:0] exp_q[$];
    logic [MSG_W-1:0] cur_msg;
    int   edge_n     = 0;
    int   start_edge = -1000;
    int   free_edge  = 0;
    logic m_ready    = 1'b0;
    logic exp_line   = 1'b0;
    logic exp_done   = 1'b0;
    logic exp_busy   = 1'b0;

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                exp_q.delete();
                m_ready    = 1'b0;
                start_edge = -1000;
                free_edge  = 0;
                exp_line   = 1'b0;
                exp_done   = 1'b0;
                exp_busy   = 1'b0;
            end else begin
                int  j;
                int  bitn;
                bit  do_pop;
                bit  do_push;
                edge_n++;
                do_pop  = (edge_n >= free_edge) && (mq.size() > 0);
                do_push = msgValid && m_ready;
                if (do_pop) begin
                    cur_msg    = mq.pop_front();
                    start_edge = edge_n;
                    free_edge  = edge_n + FRAME + 1;
                end
                if (do_push) begin
                    mq.push_back(msgIn);
                    exp_q.push_back(msgIn);
                end
                m_ready  = (mq.size() != DEPTH);
                j        = edge_n - start_edge - 1;
                exp_line = 1'b0;
                exp_done = 1'b0;
                if (j >= 0 && j < FRAME) begin
                    bitn = j / 8;
                    if (bitn == 0) exp_line = 1'b1;
                    else if (bitn <= MSG_W) exp_line = cur_msg[MSG_W - bitn];
                    exp_done = (j == FRAME - 1);
                end
                exp_busy = (edge_n < start_edge + FRAME) || (mq.size() > 0);
            end
        end
    end

    // per-cycle comparison and line decoder (scoreboard against exp_q)
    bit               rx_act = 1'b0;
    int               rx_t   = 0;
    logic [MSG_W-1:0] rx_data;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                rx_act = 1'b0;
            end else begin
                logic [31:0] exp_w;
                check("serialOut", 32'(serialOut), 32'(exp_line));
                check("frameDone", 32'(frameDone), 32'(exp_done));
                check("busy", 32'(busy), 32'(exp_busy));
                check("msgReady", 32'(msgReady), 32'(m_ready));
                if (!rx_act) begin
                    if (serialOut) begin
                        rx_act  = 1'b1;
                        rx_t    = 0;
                        rx_data = '0;
                    end
                end else begin
                    rx_t++;
                    if (rx_t == 4) begin
                        check("rx_start", 32'(serialOut), 32'd1);
                    end else if (rx_t >= 12 && rx_t <= 8 * MSG_W + 4 && (rx_t % 8) == 4) begin
                        rx_data = {rx_data[MSG_W-2:0], serialOut};
                    end else if (rx_t == 8 * (MSG_W + 1) + 4) begin
                        check("rx_stop", 32'(serialOut), 32'd0);
                        exp_w = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
                        check("rx_data", 32'(rx_data), exp_w);
                    end else if (rx_t == 8 * (MSG_W + 2)) begin
                        rx_act = 1'b0;
                    end
                end
            end
        end
    end

    // driver tasks (called at a falling edge)
    task automatic push(input logic [MSG_W-1:0] d);
        msgValid = 1'b1;
        msgIn    = d;
        @(posedge clock);
        @(negedge clock);
        msgValid = 1'b0;
        msgIn    = MSG_W'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int i;
        reset_n  = 1'b0;
        msgValid = 1'b0;
        msgIn    = '0;
        wait_cycles(3);
        check("rst_ready", 32'(msgReady), 32'd0);
        check("rst_line", 32'(serialOut), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frameDone), 32'd0);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("ready_after_rst", 32'(msgReady), 32'd1);

        // reset in the middle of the first data bit
        push(20'hABCDE);
        wait_cycles(12);
        check("pre_rst_line", 32'(serialOut), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_line", 32'(serialOut), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(msgReady), 32'd0);
        wait_cycles(3);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("ready_after_arst", 32'(msgReady), 32'd1);
        check("line_after_arst", 32'(serialOut), 32'd0);
        wait_cycles(20);

        // single frame with frameDone latency measured from the push edge
        push(20'hA5A5A);
        i = 0;
        while (!frameDone && i < 300) begin
            @(negedge clock);
            i++;
        end
        check("done_latency", 32'(i), 32'd185);
        @(negedge clock);
        check("done_pulse", 32'(frameDone), 32'd0);
        wait_cycles(5);

        // loopback-style sequence, pushed on consecutive edges
        push(20'h00001);
        push(20'hFFFFF);
        push(20'h80000);
        wait_cycles(3 * FRAME + 60);

        // FIFO full: values 1..6 offered on consecutive edges while sending
        push(20'h12345);
        for (int v = 1; v <= 6; v++) begin
            msgValid = 1'b1;
            msgIn    = MSG_W'(v);
            @(posedge clock);
            @(negedge clock);
        end
        msgValid = 1'b0;
        check("full_ready", 32'(msgReady), 32'd0);
        wait_cycles(5 * FRAME + 60);

        // back-to-back, then a push on the very edge the queued message pops
        push(20'h3C3C3);
        push(20'h0F0F0);
        i = 0;
        while (edge_n != free_edge - 1 && i < 400) begin
            @(negedge clock);
            i++;
        end
        check("pp_wait", 32'(i < 400), 32'd1);
        push(20'h5AA55);
        check("pp_ready", 32'(msgReady), 32'd1);
        check("pp_busy", 32'(busy), 32'd1);
        wait_cycles(3 * FRAME + 60);

        // random traffic; msgIn also wanders while msgValid is low
        for (int c = 0; c < 2500; c++) begin
            msgValid = ($urandom_range(0, 9) == 0);
            msgIn    = MSG_W'($urandom);
            @(negedge clock);
        end
        msgValid = 1'b0;
        wait_cycles((DEPTH + 1) * FRAME + 300);
        check("drain_q", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
